// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the writeback broadcast bus type.
package cpu_pkg;

  // Virtual register id width.
  localparam int unsigned VREG_W = 5;
  // Result data width.
  localparam int unsigned DATA_W = 32;

  // One writeback broadcast: valid, destination tag and result value.
  typedef struct packed {
    logic              en;
    logic [VREG_W-1:0] vregid;
    logic [DATA_W-1:0] val;
  } wb_bus_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: grants the first requesting slot at or after ptr,
// wrapping modulo N. Purely combinational so issue-select logic can reuse it.
module rr_priority_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [PtrW-1:0] grant_idx,
  output logic            any
);

  // Walk the slots in rotated order starting at ptr; the first hit wins.
  always_comb begin
    logic [PtrW:0]   sum;
    logic [PtrW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Explicit wrap keeps non-power-of-two N correct.
      sum = {1'b0, ptr} + (PtrW+1)'(k);
      if (sum >= (PtrW+1)'(N)) begin
        sum = sum - (PtrW+1)'(N);
      end
      idx = sum[PtrW-1:0];
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_bus_arbiter.sv
// Writeback bus arbiter: shares one registered writeback broadcast slot between
// NUM_REQ result producers. Each producer owns a single-entry holding register;
// a round-robin picker drains one entry per advancing cycle onto wb_*.
module writeback_bus_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned VREG_W  = cpu_pkg::VREG_W,
  parameter int unsigned DATA_W  = cpu_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hci_rdy,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*VREG_W-1:0]   req_vregid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_val,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        wb_en,
  output logic [VREG_W-1:0]           wb_vregid,
  output logic [DATA_W-1:0]           wb_val,
  output logic                        busy
);

  localparam int unsigned     PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);

  // Holding registers, one per requester.
  logic [NUM_REQ-1:0] hold_valid_q;
  logic [VREG_W-1:0]  hold_vregid_q [NUM_REQ];
  logic [DATA_W-1:0]  hold_val_q    [NUM_REQ];

  // Round-robin start point for the next pick.
  logic [PtrW-1:0] rr_ptr_q;

  // Registered broadcast.
  logic              wb_en_q;
  logic [VREG_W-1:0] wb_vregid_q;
  logic [DATA_W-1:0] wb_val_q;

  // Picker results.
  logic [NUM_REQ-1:0] grant;
  logic [PtrW-1:0]    grant_idx;
  logic               has_grant;

  logic               advance;
  logic [NUM_REQ-1:0] accept;

  rr_priority_picker #(
    .N    (NUM_REQ),
    .PtrW (PtrW)
  ) u_picker (
    .req       (hold_valid_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (has_grant)
  );

  // A normal edge happens only when nothing of higher priority intervenes.
  assign advance = !rst && !flush && hci_rdy;

  // A slot accepts when empty, or when it is draining this very edge.
  assign req_ready = advance ? (~hold_valid_q | grant) : '0;
  assign accept    = req_valid & req_ready;
  assign busy      = |hold_valid_q;

  // Control state: slot occupancy, round-robin pointer and broadcast valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      wb_en_q      <= 1'b0;
    end else if (flush) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      wb_en_q      <= 1'b0;
    end else if (hci_rdy) begin
      wb_en_q <= has_grant;
      if (has_grant) begin
        rr_ptr_q <= (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
      end
      // A refill of a draining slot wins over the clear.
      hold_valid_q <= (hold_valid_q & ~grant) | accept;
    end
  end

  // Holding payload: captured on accept, otherwise kept; occupancy is tracked separately.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        hold_vregid_q[i] <= req_vregid[i*VREG_W +: VREG_W];
        hold_val_q[i]    <= req_val[i*DATA_W +: DATA_W];
      end
    end
  end

  // Broadcast payload: loaded from the granted slot; kept across idle, stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vregid_q <= '0;
      wb_val_q    <= '0;
    end else if (advance && has_grant) begin
      wb_vregid_q <= hold_vregid_q[grant_idx];
      wb_val_q    <= hold_val_q[grant_idx];
    end
  end

  assign wb_en     = wb_en_q;
  assign wb_vregid = wb_vregid_q;
  assign wb_val    = wb_val_q;

endmodule
